// File: rtl/rsa_operand_sequencer.sv
// Operand loader and result collector in front of the RSA exponentiation core.
// Bytes fill P, E, M and Const MSB-first, then the core is cleared, run and its result (or a timeout) returned.
module rsa_operand_sequencer #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             core_rstb,
    output logic             core_en,
    output logic [WIDTH-1:0] P_o,
    output logic [WIDTH-1:0] E_o,
    output logic [WIDTH-1:0] M_o,
    output logic [WIDTH-1:0] Const_o,
    input  logic [WIDTH-1:0] core_C,
    input  logic             core_eoc,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
);
    localparam int BYTES = WIDTH / 8;
    localparam int NB    = 4 * BYTES;
    localparam int CW    = $clog2(NB);
    localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {LOAD, CLR, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   byte_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [CW-1:0]   word_idx;
    logic [WIDTH-1:0] in_word;

    assign word_idx = byte_cnt / CW'(BYTES);
    assign in_word  = WIDTH'(in_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            byte_cnt  <= '0;
            tmo_cnt   <= '0;
            in_ready  <= 1'b1;
            core_rstb <= 1'b1;
            core_en   <= 1'b0;
            P_o       <= '0;
            E_o       <= '0;
            M_o       <= '0;
            Const_o   <= '0;
            res_data  <= '0;
            res_err   <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (abort) begin
            // Operands keep partial contents; the next load overwrites them.
            state     <= LOAD;
            byte_cnt  <= '0;
            tmo_cnt   <= '0;
            in_ready  <= 1'b1;
            core_rstb <= 1'b1;
            core_en   <= 1'b0;
            res_err   <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        case (word_idx[1:0])
                            2'd0:    P_o     <= (P_o << 8) | in_word;
                            2'd1:    E_o     <= (E_o << 8) | in_word;
                            2'd2:    M_o     <= (M_o << 8) | in_word;
                            default: Const_o <= (Const_o << 8) | in_word;
                        endcase
                        if (byte_cnt == CW'(NB - 1)) begin
                            byte_cnt  <= '0;
                            state     <= CLR;
                            in_ready  <= 1'b0;
                            busy      <= 1'b1;
                            core_rstb <= 1'b0;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                CLR: begin
                    state     <= RUN;
                    core_rstb <= 1'b1;
                    core_en   <= 1'b1;
                    tmo_cnt   <= '0;
                end
                RUN: begin
                    // A real result beats a timeout landing in the same cycle.
                    if (core_eoc) begin
                        res_data  <= core_C;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        core_en   <= 1'b0;
                        state     <= DONE;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        res_data  <= '0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        core_en   <= 1'b0;
                        state     <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: doc/rsa_operand_sequencer.md
Name: rsa_operand_sequencer

Overview:
- Front-end controller that sits directly upstream of the RSA exponentiation core. It also handles that core's result.
- Accepts a byte stream over a valid/ready interface and assembles the four core operands in the order P, E, M, Const.
- Resets and enables the core, waits for its end-of-conversion, then returns C over a valid/ready result port.
- Provides an abort input and a timeout watchdog.

Parameters:
- WIDTH, 8, operand/result width in bits. Must be a multiple of 8 and at least 8.
- TIMEOUT, 1024, maximum number of RUN cycles to wait for core_eoc before flagging an error. Must be at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, active-high, synchronous to clk; one clock, no other clock domains
- abort  in  1  synchronous abort; returns the block to LOAD
- in_data  in  8  operand byte, MSB-first within each word
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a byte
- core_rstb  out  1  active-low reset to the core
- core_en  out  1  enable to the core
- P_o, E_o, M_o, Const_o  out  WIDTH each  operand registers driving the core
- core_C  in  WIDTH  core result
- core_eoc  in  1  core end-of-conversion
- res_data  out  WIDTH  captured result
- res_err  out  1  result is invalid because of a timeout
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- busy  out  1  high in CLR, RUN and DONE

Behaviour:
- Reset values:
  - state=LOAD, byte counter=0, timeout counter=0.
  - in_ready=1, core_rstb=1, core_en=0.
  - All operand outputs, res_data and res_err are 0; res_valid=0; busy=0.
- Byte counting: BYTES=WIDTH/8. One load takes 4*BYTES bytes; bytes 0..BYTES-1 form P, the next BYTES form E, then M, then Const.
- Byte placement: each accepted byte shifts into the selected word from the LSB end (word <= {word[WIDTH-9:0], byte}), so the first byte received ends up as the MSB.
- LOAD:
  - in_ready=1. A byte is accepted only when in_valid && in_ready.
  - On accepting the last byte (counter = 4*BYTES-1): counter resets to 0 and the next state is CLR.
  - Operand registers update only on an accepted byte.
- CLR: exactly 1 cycle. core_rstb=0, core_en=0, in_ready=0. Next state is RUN.
- RUN:
  - core_rstb=1, core_en=1. The timeout counter starts at 0 on entry and increments every cycle.
  - If core_eoc=1, at the next edge: res_data<=core_C, res_err<=0, res_valid<=1, core_en<=0, state=DONE.
  - Otherwise, if the timeout counter = TIMEOUT-1, at the next edge: res_data<=0, res_err<=1, res_valid<=1, core_en<=0, state=DONE.
  - If core_eoc and the timeout condition occur in the same cycle, core_eoc wins (normal result, res_err=0).
  - Operand outputs are held constant throughout CLR and RUN.
- DONE:
  - res_valid=1, and res_data/res_err are held stable until res_valid && res_ready.
  - On that handshake: res_valid<=0 and state=LOAD, so in_ready=1 in the following cycle.
  - core_eoc is ignored in DONE.
- core_eoc is ignored in LOAD and CLR; a stale eoc from the previous operation cannot complete a new one.
- Latency: last byte accepted at edge N gives CLR during cycle N+1 and RUN from cycle N+2. If eoc is seen in cycle K, res_valid=1 from cycle K+1.
- abort:
  - Takes priority over every transition except rst.
  - At the next edge: state=LOAD, byte counter=0, timeout counter=0, core_en=0, core_rstb=1, res_valid=0, res_err=0.
  - Operand registers keep their partial contents; they are overwritten by the next load.
  - An in_data byte presented in the same cycle as abort is not accepted.
- rst in any state, including mid-load or mid-RUN, restores all reset values at the next edge.
- Timeout counter width: $clog2(TIMEOUT). It does not wrap, because the RUN state exits at TIMEOUT-1.

Test Plan:
- Basic load, WIDTH=8, core model asserts eoc 20 cycles after RUN entry with core_C=0x07:
  - Stream 0x0D,0x05,0x0B,0x03 → P_o=0x0D, E_o=0x05, M_o=0x0B, Const_o=0x03.
  - core_rstb=0 for exactly one cycle, then core_en=1.
  - res_data=0x07, res_err=0, res_valid rises 1 cycle after eoc.
- Byte ordering, WIDTH=16: stream 0x12,0x34,0xAB,0xCD,0x00,0x11,0xFF,0x01 → P_o=0x1234, E_o=0xABCD, M_o=0x0011, Const_o=0xFF01.
- Timeout, TIMEOUT=64, core never asserts eoc → res_valid=1 and res_err=1 exactly 64 cycles after RUN entry; res_data=0; core_en=0.
- Backpressure and bubbles:
  - in_valid toggled randomly during load → only handshaked bytes are counted.
  - res_ready held low for 10 cycles → res_data/res_valid stable throughout; in_ready=1 only after the handshake.
- Abort after 2 of 4 bytes, then a full reload of 0x01,0x02,0x03,0x04 → operands equal 0x01..0x04 and exactly one CLR pulse occurs.
- Corner cases:
  - rst asserted during RUN → core_en=0, busy=0, in_ready=1 next cycle.
  - core_eoc held high during CLR → ignored.
  - eoc coincident with the timeout cycle → res_err=0.
